// File: rtl/lsu_load_wb_queue.sv
// Load writeback queue: tracks outstanding load descriptors, pairs them with in-order
// memory responses, aligns/extends the data and holds a registered register-file write.
// Optional misalignment trap enabled by defining LSU_WB_MISALIGN_CHK_EN.
module lsu_load_wb_queue #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4,
    parameter int OFFW  = $clog2(XLEN/8)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [4:0]                req_rd,
    input  logic [1:0]                req_size,
    input  logic                      req_zero_ext,
    input  logic [OFFW-1:0]           req_off,
    input  logic                      mem_valid,
    output logic                      mem_ready,
    input  logic [XLEN-1:0]           mem_data,
    output logic                      wb_valid,
    input  logic                      wb_ready,
    output logic [4:0]                wb_rd,
    output logic [XLEN-1:0]           wb_data,
    output logic                      illegal,
    output logic [$clog2(DEPTH):0]    pending
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0]   wrPtr_q, wrPtr_d;
    logic [PW-1:0]   rdPtr_q, rdPtr_d;
    logic [CW-1:0]   count_q, count_d;

    logic [4:0]      rdArr_q   [DEPTH];
    logic [1:0]      sizeArr_q [DEPTH];
    logic            zextArr_q [DEPTH];
    logic [OFFW-1:0] offArr_q  [DEPTH];

    logic            wbValid_q, wbValid_d;
    logic [4:0]      wbRd_q, wbRd_d;
    logic [XLEN-1:0] wbData_q, wbData_d;
    logic            illegal_q, illegal_d;

    logic            push, pop;
    logic [4:0]      headRd;
    logic [1:0]      headSize;
    logic            headZext;
    logic [OFFW-1:0] headOff;
    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] extData;
    logic            misaligned;
    logic            headIllegal;

    // Handshakes: ready on the request side depends only on the registered count.
    assign req_ready = (count_q != CW'(DEPTH));
    assign mem_ready = (count_q != '0) && (!wbValid_q || wb_ready);
    assign push      = req_valid && req_ready;
    assign pop       = mem_valid && mem_ready;

    assign headRd   = rdArr_q[rdPtr_q];
    assign headSize = sizeArr_q[rdPtr_q];
    assign headZext = zextArr_q[rdPtr_q];
    assign headOff  = offArr_q[rdPtr_q];

    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (push) begin
            wrPtr_d = wrPtr_q + PW'(1);
        end
        if (pop) begin
            rdPtr_d = rdPtr_q + PW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!push && pop) begin
            count_d = count_q - CW'(1);
        end
    end

    // Bytes shifted in from above the beat are zero, so over-reads extend from zero.
    always_comb begin
        int   fieldBits;
        logic signBit;
        logic fill;
        shifted   = mem_data >> {headOff, 3'b000};
        fieldBits = XLEN;
        signBit   = 1'b0;
        case (headSize)
            2'b00: begin
                fieldBits = 8;
                signBit   = shifted[7];
            end
            2'b01: begin
                fieldBits = 16;
                signBit   = shifted[15];
            end
            2'b10: begin
                fieldBits = 32;
                signBit   = shifted[31];
            end
            default: begin
                fieldBits = XLEN;
                signBit   = shifted[XLEN-1];
            end
        endcase
        fill    = !headZext && signBit;
        extData = '0;
        for (int i = 0; i < XLEN; i++) begin
            extData[i] = (i < fieldBits) ? shifted[i] : fill;
        end
    end

`ifdef LSU_WB_MISALIGN_CHK_EN
    always_comb begin
        logic [OFFW-1:0] alignMask;
        alignMask = '0;
        case (headSize)
            2'b00:   alignMask = '0;
            2'b01:   alignMask = OFFW'(1);
            2'b10:   alignMask = OFFW'(3);
            default: alignMask = OFFW'(7);
        endcase
        misaligned = ((headOff & alignMask) != '0);
    end
`else
    assign misaligned = 1'b0;
`endif

    assign headIllegal = ((headSize == 2'b11) && ((XLEN == 32) || headZext)) || misaligned;

    // Writeback register: a pop in the same cycle as wb_ready reloads it back to back.
    always_comb begin
        wbValid_d = wbValid_q;
        wbRd_d    = wbRd_q;
        wbData_d  = wbData_q;
        illegal_d = 1'b0;
        if (wbValid_q && wb_ready) begin
            wbValid_d = 1'b0;
        end
        if (pop) begin
            if (headIllegal) begin
                illegal_d = 1'b1;
            end else if (headRd != 5'd0) begin
                wbValid_d = 1'b1;
                wbRd_d    = headRd;
                wbData_d  = extData;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr_q   <= '0;
            rdPtr_q   <= '0;
            count_q   <= '0;
            wbValid_q <= 1'b0;
            wbRd_q    <= '0;
            wbData_q  <= '0;
            illegal_q <= 1'b0;
        end else begin
            wrPtr_q   <= wrPtr_d;
            rdPtr_q   <= rdPtr_d;
            count_q   <= count_d;
            wbValid_q <= wbValid_d;
            wbRd_q    <= wbRd_d;
            wbData_q  <= wbData_d;
            illegal_q <= illegal_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            rdArr_q[wrPtr_q]   <= req_rd;
            sizeArr_q[wrPtr_q] <= req_size;
            zextArr_q[wrPtr_q] <= req_zero_ext;
            offArr_q[wrPtr_q]  <= req_off;
        end
    end

    assign wb_valid = wbValid_q;
    assign wb_rd    = wbRd_q;
    assign wb_data  = wbData_q;
    assign illegal  = illegal_q;
    assign pending  = count_q;

endmodule

// File: tb/tb_lsu_load_wb_queue.sv
// Scoreboard bench for lsu_load_wb_queue (XLEN=32, DEPTH=4): directed cases then
// randomized traffic, checked against a byte-level reference model.
module tb_lsu_load_wb_queue;

    localparam int XLEN  = 32;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [4:0]  req_rd = '0;
    logic [1:0]  req_size = '0;
    logic        req_zero_ext = 1'b0;
    logic [1:0]  req_off = '0;
    logic        mem_valid = 1'b0;
    logic        mem_ready;
    logic [31:0] mem_data = '0;
    logic        wb_valid;
    logic        wb_ready = 1'b0;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        illegal;
    logic [2:0]  pending;

    lsu_load_wb_queue #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_rd(req_rd),
        .req_size(req_size), .req_zero_ext(req_zero_ext), .req_off(req_off),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_data(mem_data),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
        .illegal(illegal), .pending(pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] rd;
        logic [1:0] size;
        bit         zext;
        logic [1:0] off;
    } desc_t;

    typedef struct {
        bit          ill;
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;

    desc_t descQ[$];
    exp_t  expQ[$];
    int    modelCount = 0;
    bit    modelBusy = 1'b0;
    int    checks = 0;
    int    errors = 0;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: take the addressed bytes of the beat, then extend from the field width.
    function automatic logic [31:0] modelData(logic [31:0] md, logic [1:0] sz, bit zx, logic [1:0] off);
        logic [63:0] v;
        logic [63:0] mask;
        int          nb;
        v    = {32'd0, md} >> (int'(off) * 8);
        nb   = 1 << sz;
        mask = (nb >= 8) ? '1 : ((64'd1 << (nb * 8)) - 64'd1);
        v    = v & mask;
        if (!zx && v[nb*8-1]) v = v | ~mask;
        return v[31:0];
    endfunction

    function automatic bit modelIllegal(logic [1:0] sz, logic [1:0] off);
        bit ill;
        ill = (sz == 2'b11);
`ifdef LSU_WB_MISALIGN_CHK_EN
        if ((int'(off) % (1 << sz)) != 0) ill = 1'b1;
`endif
        return ill;
    endfunction

    // One clock of stimulus; the model decides which handshakes happen at the next edge.
    task automatic applyStimulus(input bit rv, input logic [4:0] rd, input logic [1:0] sz,
                                 input bit zx, input logic [1:0] off, input bit mv,
                                 input logic [31:0] md, input bit wr);
        bit   expMemReady;
        bit   doPush;
        bit   doPop;
        bit   makesWrite;
        desc_t d;
        exp_t  e;
        @(negedge clk);
        req_valid = rv; req_rd = rd; req_size = sz; req_zero_ext = zx; req_off = off;
        mem_valid = mv; mem_data = md; wb_ready = wr;
        #1;
        checkOutput("pending", 64'(pending), 64'(modelCount));
        checkOutput("req_ready", 64'(req_ready), 64'(modelCount != DEPTH));
        expMemReady = (modelCount != 0) && (!modelBusy || wr);
        checkOutput("mem_ready", 64'(mem_ready), 64'(expMemReady));
        doPush = rv && (modelCount != DEPTH);
        doPop  = mv && expMemReady;
        makesWrite = 1'b0;
        if (doPop) begin
            d = descQ.pop_front();
            if (modelIllegal(d.size, d.off)) begin
                e.ill = 1'b1; e.rd = '0; e.data = '0;
                expQ.push_back(e);
            end else if (d.rd != 5'd0) begin
                e.ill = 1'b0; e.rd = d.rd; e.data = modelData(md, d.size, d.zext, d.off);
                expQ.push_back(e);
                makesWrite = 1'b1;
            end
        end
        if (makesWrite) modelBusy = 1'b1;
        else if (wr) modelBusy = 1'b0;
        if (doPush) begin
            d.rd = rd; d.size = sz; d.zext = zx; d.off = off;
            descQ.push_back(d);
        end
        modelCount = modelCount + int'(doPush) - int'(doPop);
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b1; req_valid = 1'b0; mem_valid = 1'b0; wb_ready = 1'b0;
        descQ.delete(); expQ.delete();
        modelCount = 0; modelBusy = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("reset_pending", 64'(pending), 64'd0);
        checkOutput("reset_wb_valid", 64'(wb_valid), 64'd0);
        checkOutput("reset_wb_rd", 64'(wb_rd), 64'd0);
        checkOutput("reset_wb_data", 64'(wb_data), 64'd0);
        checkOutput("reset_illegal", 64'(illegal), 64'd0);
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && (modelCount != 0 || modelBusy); i++) begin
            applyStimulus(1'b0, 5'd0, 2'b00, 1'b0, 2'd0, 1'b1, $urandom, 1'b1);
        end
        checkOutput("drain_count", 64'(modelCount), 64'd0);
        repeat (2) applyStimulus(1'b0, 5'd0, 2'b00, 1'b0, 2'd0, 1'b0, 32'd0, 1'b1);
        checkOutput("scoreboard_empty", 64'(expQ.size()), 64'd0);
    endtask

    // Monitor: every write handshake and illegal pulse must match the oldest expectation.
    always @(negedge clk) begin
        #2;
        if (!rst) begin
            if (wb_valid && wb_ready) begin
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL wb_unexpected: got write rd=%0d data=0x%0h, none expected", wb_rd, wb_data);
                end else begin
                    exp_t e;
                    e = expQ.pop_front();
                    checkOutput("wb_kind_ill", 64'(1'b0), 64'(e.ill));
                    checkOutput("wb_rd", 64'(wb_rd), 64'(e.rd));
                    checkOutput("wb_data", 64'(wb_data), 64'(e.data));
                end
            end
            if (illegal) begin
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL illegal_unexpected: got pulse, none expected");
                end else begin
                    exp_t e;
                    e = expQ.pop_front();
                    checkOutput("illegal_kind", 64'(1'b1), 64'(e.ill));
                end
            end
        end
    end

    initial begin
        doReset();

        // Signed and unsigned byte at offset 2, signed half at offset 2.
        applyStimulus(1'b1, 5'd5, 2'b00, 1'b0, 2'd2, 1'b0, 32'd0, 1'b1);
        applyStimulus(1'b0, 5'd0, 2'b00, 1'b0, 2'd0, 1'b1, 32'h12F45678, 1'b1);
        applyStimulus(1'b1, 5'd5, 2'b00, 1'b1, 2'd2, 1'b0, 32'd0, 1'b1);
        applyStimulus(1'b0, 5'd0, 2'b00, 1'b0, 2'd0, 1'b1, 32'h12F45678, 1'b1);
        applyStimulus(1'b1, 5'd7, 2'b01, 1'b0, 2'd2, 1'b0, 32'd0, 1'b1);
        applyStimulus(1'b0, 5'd0, 2'b00, 1'b0, 2'd0, 1'b1, 32'h80001234, 1'b1);
        drain();

        // Fill to DEPTH, refuse a fifth, then push+pop together at pending=3.
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(1'b1, 5'(i), 2'b10, 1'b0, 2'd0, 1'b0, 32'd0, 1'b1);
        end
        applyStimulus(1'b0, 5'd0, 2'b00, 1'b0, 2'd0, 1'b1, 32'hDEADBEEF, 1'b1);
        applyStimulus(1'b1, 5'd9, 2'b01, 1'b1, 2'd0, 1'b1, 32'h0BADF00D, 1'b1);
        applyStimulus(1'b0, 5'd0, 2'b00, 1'b0, 2'd0, 1'b0, 32'd0, 1'b1);

        // Backpressure: hold wb_ready low, then release for back-to-back writes.
        applyStimulus(1'b0, 5'd0, 2'b00, 1'b0, 2'd0, 1'b1, 32'h11223344, 1'b0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 5'd0, 2'b00, 1'b0, 2'd0, 1'b1, 32'h55667788, 1'b0);
        end
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 5'd0, 2'b00, 1'b0, 2'd0, 1'b1, 32'h99AABB00 + 32'(i), 1'b1);
        end
        drain();

        // rd=0 load and an illegal dword: no writes, one illegal pulse.
        applyStimulus(1'b1, 5'd0, 2'b00, 1'b0, 2'd1, 1'b0, 32'd0, 1'b1);
        applyStimulus(1'b1, 5'd9, 2'b11, 1'b0, 2'd0, 1'b0, 32'd0, 1'b1);
        applyStimulus(1'b0, 5'd0, 2'b00, 1'b0, 2'd0, 1'b1, 32'hCAFEBABE, 1'b1);
        applyStimulus(1'b0, 5'd0, 2'b00, 1'b0, 2'd0, 1'b1, 32'h01234567, 1'b1);
        drain();

        // Misaligned word at offset 1.
        applyStimulus(1'b1, 5'd3, 2'b10, 1'b0, 2'd1, 1'b0, 32'd0, 1'b1);
        applyStimulus(1'b0, 5'd0, 2'b00, 1'b0, 2'd0, 1'b1, 32'hAABBCCDD, 1'b1);
        drain();

        // Randomized traffic with a reset in the middle.
        for (int i = 0; i < 3000; i++) begin
            logic [1:0] sz;
            sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            if (i == 1500) doReset();
            applyStimulus($urandom_range(0, 99) < 60,
                          ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom),
                          sz, 1'($urandom), 2'($urandom),
                          $urandom_range(0, 99) < 60, $urandom,
                          $urandom_range(0, 99) < 70);
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lsu_load_wb_queue.md
Name: lsu_load_wb_queue

Overview:
- Parametrised load-writeback unit for the LSU; it supersedes the purely combinational writeback path.
- Holds up to DEPTH outstanding load descriptors issued by the LSU and pairs each with the in-order memory response.
- Aligns the response by byte offset and sign- or zero-extends it by size.
- Presents a registered write to the register file port under a valid/ready handshake. Stores never enter this block.

Parameters:
- XLEN, 32, data and register width; legal values 32 or 64.
- DEPTH, 4, pending-load queue entries; power of two, minimum 2.
- OFFW, $clog2(XLEN/8), byte-offset width (derived; do not override).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  load descriptor valid.
- req_ready  out  1  queue can accept a descriptor.
- req_rd  in  5  destination register.
- req_size  in  2  00 byte, 01 half, 10 word, 11 dword.
- req_zero_ext  in  1  1 = unsigned load.
- req_off  in  OFFW  byte offset within the XLEN-wide memory beat.
- mem_valid  in  1  memory response valid.
- mem_ready  out  1  response accepted.
- mem_data  in  XLEN  raw memory beat.
- wb_valid  out  1  register write pending.
- wb_ready  in  1  register file accepts write.
- wb_rd  out  5  register index.
- wb_data  out  XLEN  extended load result.
- illegal  out  1  one-cycle pulse: the popped descriptor was illegal.
- pending  out  $clog2(DEPTH)+1  occupancy count.

Behaviour:
- Reset: queue empty, pending=0, wb_valid=0, wb_rd=0, wb_data=0, illegal=0. Reset mid-operation discards all queued descriptors and any held writeback; memory responses arriving afterwards are the requester's responsibility.
- Request side:
  - req_ready = (pending != DEPTH); it is derived from registered count only.
  - A push occurs when req_valid && req_ready.
- Response side:
  - mem_ready = (pending != 0) && (!wb_valid || wb_ready).
  - A pop occurs when mem_valid && mem_ready; the head descriptor is paired with mem_data. Responses are strictly in order.
  - mem_valid while the queue is empty is ignored: mem_ready=0, no state change.
- Simultaneous push and pop in the same cycle: pending is unchanged and both succeed, including at pending=DEPTH-1 and pending=1. Pointers wrap modulo DEPTH.
- Datapath on pop:
  - shifted = mem_data >> (off*8).
  - Byte: bits [7:0]. Half: [15:0]. Word: [31:0]. Dword: full XLEN.
  - Fill upper bits with zeros if zero_ext=1, otherwise with the top bit of the selected field.
  - Word with XLEN=32 ignores zero_ext; unsigned word is legal.
- Illegal descriptors: size=11 with XLEN=32, or size=11 with zero_ext=1.
  - On pop of an illegal descriptor: illegal=1 for one cycle, wb_valid stays 0, and the response is still consumed.
- Writeback stage:
  - Output register, latency 1 cycle from pop to wb_valid=1.
  - rd=0 descriptors are consumed with no writeback: wb_valid stays 0, no pulse.
  - wb_valid holds with wb_rd and wb_data stable until wb_ready=1.
  - A new pop in the same cycle as wb_ready=1 reloads the register back to back, giving one write per cycle of throughput.
- No combinational path from wb_ready to req_ready.

Optional Feature:
- Macro: LSU_WB_MISALIGN_CHK_EN.
- When defined:
  - A descriptor whose off is not a multiple of the access size (half: off[0]!=0; word: off[1:0]!=0; dword: off[2:0]!=0) is treated as illegal.
  - Behaviour is the same as other illegal descriptors: illegal pulse, no writeback, response consumed.
- When undefined:
  - Misalignment is not checked and data is taken from the shifted beat.
  - Bytes beyond the beat read as zero before extension.

Test Plan:
1. XLEN=32: push {rd=5, byte, signed, off=2}, then mem_data=0x12F45678 → next cycle wb_valid=1, wb_rd=5, wb_data=0xFFFFFFF4.
2. Same descriptor with zero_ext=1 → wb_data=0x000000F4. Half, off=2, signed, mem_data=0x80001234 → 0xFFFF8000.
3. DEPTH=4: push 4 descriptors with no responses → req_ready=0, pending=4. Then push and pop in the same cycle with pending=3 → pending stays 3.
4. Hold wb_ready=0 for 3 cycles with 2 responses queued → mem_ready=0 and wb_data stable. Release → two writes on consecutive cycles.
5. rd=0 load, then size=11 on XLEN=32 → no wb_valid for either, illegal pulses once, pending decrements by 2.
6. With LSU_WB_MISALIGN_CHK_EN: word load at off=1 → illegal=1, no write. Without the macro: mem_data=0xAABBCCDD gives wb_data=0x00AABBCC.
